// File: rtl/bsg_axil_irq_pkg.sv
// Shared types for the AXI-lite interrupt register block: write FSM states,
// AXI response codes and the index-width helper.
package bsg_axil_irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HAVE_AW = 2'd1,
        HAVE_W  = 2'd2,
        RESP    = 2'd3
    } wr_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // A single line still needs a one-bit index port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bsg_axil_irq_decode.sv
// Address decoder: word-aligned hit inside the IRQ window and the line index.
module bsg_axil_irq_decode
    import bsg_axil_irq_pkg::*;
#(
    parameter int          axil_addr_width_p = 32,
    parameter int unsigned irq_base_addr_p   = 32'h300000,
    parameter int          irq_sources_p     = 2,
    parameter int          idx_w_p           = 1
) (
    input  logic [axil_addr_width_p-1:0] addr_i,
    output logic                         hit_o,
    output logic [idx_w_p-1:0]           idx_o
);

    localparam logic [axil_addr_width_p-1:0] base_lp  = axil_addr_width_p'(irq_base_addr_p);
    localparam logic [axil_addr_width_p-1:0] limit_lp =
        axil_addr_width_p'(64'(irq_base_addr_p) + 64'(4 * irq_sources_p));

    logic [axil_addr_width_p-1:0] offset;

    always_comb begin
        offset = addr_i - base_lp;
        hit_o  = (addr_i >= base_lp) && (addr_i < limit_lp) && (addr_i[1:0] == 2'b00);
        idx_o  = idx_w_p'(offset >> 2);
    end

endmodule

// File: rtl/bsg_axil_to_irq.sv
// AXI-lite slave exposing one writable/readable register bit per interrupt
// line; irq_o drives the registered levels directly.
module bsg_axil_to_irq
    import bsg_axil_irq_pkg::*;
#(
    parameter int          axil_data_width_p = 32,
    parameter int          axil_addr_width_p = 32,
    parameter int unsigned irq_base_addr_p   = 32'h300000,
    parameter int          irq_sources_p     = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,

    input  logic [axil_addr_width_p-1:0]   s_axil_awaddr_i,
    input  logic [2:0]                     s_axil_awprot_i,
    input  logic                           s_axil_awvalid_i,
    output logic                           s_axil_awready_o,
    input  logic [axil_data_width_p-1:0]   s_axil_wdata_i,
    input  logic [axil_data_width_p/8-1:0] s_axil_wstrb_i,
    input  logic                           s_axil_wvalid_i,
    output logic                           s_axil_wready_o,
    output logic [1:0]                     s_axil_bresp_o,
    output logic                           s_axil_bvalid_o,
    input  logic                           s_axil_bready_i,

    input  logic [axil_addr_width_p-1:0]   s_axil_araddr_i,
    input  logic [2:0]                     s_axil_arprot_i,
    input  logic                           s_axil_arvalid_i,
    output logic                           s_axil_arready_o,
    output logic [axil_data_width_p-1:0]   s_axil_rdata_o,
    output logic [1:0]                     s_axil_rresp_o,
    output logic                           s_axil_rvalid_o,
    input  logic                           s_axil_rready_i,

    output logic [irq_sources_p-1:0]       irq_o
);

    localparam int idx_w_lp = idx_width(irq_sources_p);

    wr_state_e                      state_q, state_d;
    logic [axil_addr_width_p-1:0]   awaddr_q, awaddr_d;
    logic                           wdata_q, wdata_d;
    logic                           wstrb_q, wstrb_d;
    logic [irq_sources_p-1:0]       irq_q, irq_d;
    logic [1:0]                     bresp_q, bresp_d;
    logic                           rvalid_q, rvalid_d;
    logic [axil_data_width_p-1:0]   rdata_q, rdata_d;
    logic [1:0]                     rresp_q, rresp_d;

    logic                           aw_hs, w_hs, ar_hs, do_write;
    logic [axil_addr_width_p-1:0]   wr_addr;
    logic                           wr_data, wr_strb;
    logic                           wr_hit, rd_hit;
    logic [idx_w_lp-1:0]            wr_idx, rd_idx;

    // Protection bits and everything above data/strobe bit 0 carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{s_axil_awprot_i, s_axil_arprot_i, s_axil_wdata_i, s_axil_wstrb_i};

    // Readies and valids are decoded from registered state only.
    assign s_axil_awready_o = (state_q == IDLE) || (state_q == HAVE_W);
    assign s_axil_wready_o  = (state_q == IDLE) || (state_q == HAVE_AW);
    assign s_axil_bvalid_o  = (state_q == RESP);
    assign s_axil_bresp_o   = bresp_q;
    assign s_axil_arready_o = ~rvalid_q;
    assign s_axil_rvalid_o  = rvalid_q;
    assign s_axil_rdata_o   = rdata_q;
    assign s_axil_rresp_o   = rresp_q;
    assign irq_o            = irq_q;

    assign aw_hs = s_axil_awvalid_i & s_axil_awready_o;
    assign w_hs  = s_axil_wvalid_i  & s_axil_wready_o;
    assign ar_hs = s_axil_arvalid_i & s_axil_arready_o;

    // Whichever channel arrived first is replayed from its latch.
    assign wr_addr = (state_q == HAVE_AW) ? awaddr_q : s_axil_awaddr_i;
    assign wr_data = (state_q == HAVE_W)  ? wdata_q  : s_axil_wdata_i[0];
    assign wr_strb = (state_q == HAVE_W)  ? wstrb_q  : s_axil_wstrb_i[0];

    bsg_axil_irq_decode #(
        .axil_addr_width_p(axil_addr_width_p),
        .irq_base_addr_p  (irq_base_addr_p),
        .irq_sources_p    (irq_sources_p),
        .idx_w_p          (idx_w_lp)
    ) u_wr_decode (
        .addr_i(wr_addr),
        .hit_o (wr_hit),
        .idx_o (wr_idx)
    );

    bsg_axil_irq_decode #(
        .axil_addr_width_p(axil_addr_width_p),
        .irq_base_addr_p  (irq_base_addr_p),
        .irq_sources_p    (irq_sources_p),
        .idx_w_p          (idx_w_lp)
    ) u_rd_decode (
        .addr_i(s_axil_araddr_i),
        .hit_o (rd_hit),
        .idx_o (rd_idx)
    );

    always_comb begin
        state_d  = state_q;
        awaddr_d = awaddr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        irq_d    = irq_q;
        bresp_d  = bresp_q;
        do_write = 1'b0;
        case (state_q)
            IDLE: begin
                if (aw_hs && w_hs) begin
                    state_d  = RESP;
                    do_write = 1'b1;
                end else if (aw_hs) begin
                    state_d  = HAVE_AW;
                    awaddr_d = s_axil_awaddr_i;
                end else if (w_hs) begin
                    state_d = HAVE_W;
                    wdata_d = s_axil_wdata_i[0];
                    wstrb_d = s_axil_wstrb_i[0];
                end
            end
            HAVE_AW: if (w_hs) begin
                state_d  = RESP;
                do_write = 1'b1;
            end
            HAVE_W: if (aw_hs) begin
                state_d  = RESP;
                do_write = 1'b1;
            end
            RESP: if (s_axil_bready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (do_write) begin
            bresp_d = wr_hit ? RESP_OKAY : RESP_SLVERR;
            if (wr_hit && wr_strb) irq_d[wr_idx] = wr_data;
        end
    end

    // Read data is sampled at the AR handshake, so it sees pre-write levels.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = axil_data_width_p'(rd_hit & irq_q[rd_idx]);
            rresp_d  = rd_hit ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_q && s_axil_rready_i) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            awaddr_q <= '0;
            wdata_q  <= 1'b0;
            wstrb_q  <= 1'b0;
            irq_q    <= '0;
            bresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            state_q  <= state_d;
            awaddr_q <= awaddr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            irq_q    <= irq_d;
            bresp_q  <= bresp_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
        end
    end

endmodule

// File: tb/tb_bsg_axil_to_irq.sv
// Scoreboard bench for bsg_axil_to_irq: directed scenarios plus random
// AXI-lite traffic checked against a bit-array model of the IRQ registers.
module tb_bsg_axil_to_irq;

    localparam int          N    = 2;
    localparam logic [31:0] BASE = 32'h300000;

    logic        clk_i, rst_ni;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic [N-1:0] irq;

    bsg_axil_to_irq #(
        .axil_data_width_p(32),
        .axil_addr_width_p(32),
        .irq_base_addr_p  (32'h300000),
        .irq_sources_p    (N)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .s_axil_awaddr_i (awaddr),
        .s_axil_awprot_i (awprot),
        .s_axil_awvalid_i(awvalid),
        .s_axil_awready_o(awready),
        .s_axil_wdata_i  (wdata),
        .s_axil_wstrb_i  (wstrb),
        .s_axil_wvalid_i (wvalid),
        .s_axil_wready_o (wready),
        .s_axil_bresp_o  (bresp),
        .s_axil_bvalid_o (bvalid),
        .s_axil_bready_i (bready),
        .s_axil_araddr_i (araddr),
        .s_axil_arprot_i (arprot),
        .s_axil_arvalid_i(arvalid),
        .s_axil_arready_o(arready),
        .s_axil_rdata_o  (rdata),
        .s_axil_rresp_o  (rresp),
        .s_axil_rvalid_o (rvalid),
        .s_axil_rready_i (rready),
        .irq_o           (irq)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc++;

    typedef struct { logic [1:0] resp; logic [N-1:0] irq; } b_exp_t;
    typedef struct { logic [31:0] data; logic [1:0] resp; } r_exp_t;

    b_exp_t bq[$];
    r_exp_t rq[$];
    int     lat_q[$];
    logic [N-1:0] m_irq;
    bit hold_b, hold_r;
    int checks = 0, passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: the register window as a plain bit array.
    function automatic bit m_hit(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 4 * N) && (a % 4 == 0);
    endfunction

    task automatic exp_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        b_exp_t e;
        if (m_hit(a)) begin
            if (s[0]) m_irq[(a - BASE) / 4] = d[0];
            e.resp = 2'b00;
        end else e.resp = 2'b10;
        e.irq = m_irq;
        bq.push_back(e);
    endtask

    task automatic exp_read(input logic [31:0] a);
        r_exp_t e;
        e.data = m_hit(a) ? 32'(m_irq[(a - BASE) / 4]) : 32'd0;
        e.resp = m_hit(a) ? 2'b00 : 2'b10;
        rq.push_back(e);
    endtask

    task automatic drv_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int awd, input int wd);
        int  aw_c, w_c;
        bit  aw_ok, w_ok;
        aw_ok = 0; w_ok = 0; aw_c = 0; w_c = 0;
        fork
            begin
                repeat (awd) begin @(posedge clk_i); #1; end
                awaddr = a; awvalid = 1'b1;
                for (int k = 0; k < 100 && !aw_ok; k++) begin
                    @(negedge clk_i);
                    if (awready) begin @(posedge clk_i); #1 aw_c = cyc; awvalid = 1'b0; aw_ok = 1; end
                end
                if (!aw_ok) begin check("aw_timeout", 0, 1); awvalid = 1'b0; end
            end
            begin
                repeat (wd) begin @(posedge clk_i); #1; end
                wdata = d; wstrb = s; wvalid = 1'b1;
                for (int k = 0; k < 100 && !w_ok; k++) begin
                    @(negedge clk_i);
                    if (wready) begin @(posedge clk_i); #1 w_c = cyc; wvalid = 1'b0; w_ok = 1; end
                end
                if (!w_ok) begin check("w_timeout", 0, 1); wvalid = 1'b0; end
            end
        join
        if (aw_ok && w_ok) lat_q.push_back(aw_c > w_c ? aw_c : w_c);
    endtask

    task automatic drv_read(input logic [31:0] a);
        bit ok;
        ok = 0;
        araddr = a; arvalid = 1'b1;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk_i);
            if (arready) begin @(posedge clk_i); #1 arvalid = 1'b0; ok = 1; end
        end
        if (!ok) begin check("ar_timeout", 0, 1); arvalid = 1'b0; end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(posedge clk_i); #1;
            if (bq.size() == 0 && rq.size() == 0) ok = 1;
        end
        if (!ok) check("drain_timeout", 0, 1);
    endtask

    task automatic ready_driver();
        forever begin
            @(posedge clk_i); #1;
            bready = hold_b ? 1'b0 : ($urandom_range(0, 3) != 0);
            rready = hold_r ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic monitor();
        logic bv_p, rv_p, rhs_p;
        logic [1:0] bresp_p, rresp_p;
        logic [31:0] rdata_p;
        b_exp_t be;
        r_exp_t re;
        bv_p = 0; rv_p = 0; rhs_p = 0; bresp_p = 0; rresp_p = 0; rdata_p = 0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                bv_p = 0; rv_p = 0; rhs_p = 0;
            end else begin
                if (bvalid) begin
                    check("aw_w_blocked_during_b", {30'd0, awready, wready}, 0);
                    if (!bv_p) begin
                        if (lat_q.size() == 0) check("b_unexpected", 1, 0);
                        else check("b_latency", cyc, lat_q.pop_front());
                    end else check("bresp_stable", bresp, bresp_p);
                    if (bready) begin
                        if (bq.size() == 0) check("b_unexpected_hs", 1, 0);
                        else begin
                            be = bq.pop_front();
                            check("bresp", bresp, be.resp);
                            check("irq_o", irq, be.irq);
                        end
                    end
                end
                if (rvalid) begin
                    check("arready_busy", arready, 0);
                    if (rv_p && !rhs_p) begin
                        check("rdata_stable", rdata, rdata_p);
                        check("rresp_stable", rresp, rresp_p);
                    end
                    if (rready) begin
                        if (rq.size() == 0) check("r_unexpected", 1, 0);
                        else begin
                            re = rq.pop_front();
                            check("rdata", rdata, re.data);
                            check("rresp", rresp, re.resp);
                        end
                    end
                end
                bv_p = bvalid; bresp_p = bresp;
                rv_p = rvalid; rdata_p = rdata; rresp_p = rresp; rhs_p = rvalid && rready;
            end
        end
    endtask

    initial begin
        logic [31:0] a, d;
        logic [3:0]  s;
        rst_ni = 1'b0;
        awaddr = 0; awprot = 3'b101; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
        araddr = 0; arprot = 3'b010; arvalid = 0; bready = 0; rready = 0;
        hold_b = 0; hold_r = 0; m_irq = '0;
        fork
            monitor();
            ready_driver();
            begin
                #500000;
                $display("FAIL watchdog: run did not finish");
                $fatal(1, "watchdog");
            end
        join_none

        #3;
        check("rst_irq", irq, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_bresp", bresp, 0);
        check("rst_rresp", rresp, 0);
        @(negedge clk_i); @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        check("post_rst_ready", {29'd0, awready, wready, arready}, 32'h7);

        // Same-cycle AW+W to line 1.
        exp_write(BASE + 4, 1, 4'hF);
        drv_write(BASE + 4, 1, 4'hF, 0, 0);
        wait_idle();
        check("irq_after_line1", irq, 2'b10);

        // W first, AW three cycles later.
        exp_write(BASE, 1, 4'hF);
        fork
            drv_write(BASE, 1, 4'hF, 3, 0);
            begin
                @(negedge clk_i); @(negedge clk_i);
                check("have_w_awready", awready, 1);
                check("have_w_wready", wready, 0);
            end
        join
        wait_idle();
        check("irq_after_line0", irq, 2'b11);

        // Out-of-range and unaligned writes.
        exp_write(BASE + 8, 0, 4'hF);
        drv_write(BASE + 8, 0, 4'hF, 0, 1);
        exp_write(BASE + 2, 0, 4'hF);
        drv_write(BASE + 2, 0, 4'hF, 1, 0);
        wait_idle();

        // Back-pressured B, next write queued behind it.
        hold_b = 1;
        exp_write(BASE + 4, 0, 4'hF);
        drv_write(BASE + 4, 0, 4'hF, 0, 0);
        exp_write(BASE + 4, 1, 4'h1);
        fork
            drv_write(BASE + 4, 1, 4'h1, 0, 0);
            begin repeat (5) @(posedge clk_i); #1 hold_b = 0; end
        join
        wait_idle();

        // Reads with rready held low, then a miss.
        hold_r = 1;
        exp_read(BASE + 4);
        drv_read(BASE + 4);
        repeat (4) @(posedge clk_i);
        #1 hold_r = 0;
        wait_idle();
        exp_read(BASE + 32'h10);
        drv_read(BASE + 32'h10);
        wait_idle();

        // Read and write final handshake in the same cycle: read sees old level.
        exp_read(BASE);
        exp_write(BASE, 0, 4'hF);
        fork
            drv_read(BASE);
            drv_write(BASE, 0, 4'hF, 0, 0);
        join
        wait_idle();

        // Hit with strobe bit 0 clear leaves the line alone.
        exp_write(BASE + 4, 0, 4'hE);
        drv_write(BASE + 4, 0, 4'hE, 0, 0);
        wait_idle();

        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 5))
                0: a = BASE;
                1: a = BASE + 4;
                2: a = BASE + 8;
                3: a = BASE + 2;
                4: a = BASE - 4;
                default: a = BASE + $urandom_range(0, 15);
            endcase
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                exp_write(a, d, s);
                drv_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3));
            end else begin
                exp_read(a);
                drv_read(a);
            end
        end
        wait_idle();

        // Reset with a write parked in HAVE_AW and a read response pending.
        hold_r = 1;
        exp_read(BASE + 4);
        drv_read(BASE + 4);
        awaddr = BASE; awvalid = 1'b1;
        @(posedge clk_i); #1 awvalid = 1'b0;
        check("have_aw_ready", {30'd0, awready, wready}, 32'h1);
        #2 rst_ni = 1'b0;
        #1;
        check("async_rst_outputs", {bvalid, rvalid, bresp, rresp, 28'(irq)}, 0);
        check("async_rst_rdata", rdata, 0);
        bq.delete(); rq.delete(); lat_q.delete();
        m_irq = '0;
        hold_r = 0;
        @(negedge clk_i); @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        check("rerst_ready", {29'd0, awready, wready, arready}, 32'h7);
        repeat (10) @(posedge clk_i);
        #1;
        check("no_resp_after_rst", {30'd0, bvalid, rvalid}, 0);
        check("irq_after_rerst", irq, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
